// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the ID-stage decode fields, the EX redirect and the hazard-control
// responses of hazard_ctrl into one interface.
//
// Signals
//   id_valid     ID holds a valid instruction
//   id_opcode    7-bit opcode of the ID instruction
//   id_rs1/rs2   source register fields of the ID instruction
//   id_rd        destination register field of the ID instruction
//   ex_redirect  taken branch/jal/jalr resolved in EX
//   stall_if     hold the PC
//   stall_id     hold the IF/ID register
//   flush_id     clear IF/ID
//   flush_ex     inject a bubble into ID/EX
//   fwd_a/fwd_b  operand source for the instruction in EX
//                (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt    saturating count of stall cycles
//
// Modports
//   master  pipeline side: drives decode fields, receives controls
//   slave   hazard_ctrl side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_redirect;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        input  stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        output stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard detection, flush control and operand-forward selection for a
// five-stage in-order pipeline.  Tracks the destination of the instructions
// sitting in EX and MEM and compares them with the sources of the instruction
// in ID.
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    hazard_ctrl_if.slave (decode fields in, stall/flush/forward out)
//
// Configuration
//   HAZARD_CTRL_FORWARD_EN  defined: full forwarding, stall only on load-use
//                           undefined: no forwarding, stall on any RAW hazard
//                           against EX or MEM (regfile write-through covers WB)
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    // Destination tracking for a pipeline slot.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
    } slot_t;

    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    slot_t  ex_slot;
    slot_t  mem_slot;
    state_t state;
    state_t state_next;
    logic [15:0] cnt_q;
    logic [15:0] cnt_next;

    logic use_rs1;
    logic use_rs2;
    logic wr_rd;
    logic hit_ex_a;
    logic hit_ex_b;
    logic hit_mem_a;
    logic hit_mem_b;
    logic need_stall;
    logic stall;
    logic issue;

    // ------------------------------------------------------------------
    // Opcode classification of the ID instruction
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        case (bus.id_opcode)
            OP_JALR:   begin use_rs1 = 1'b1;                   wr_rd = 1'b1; end
            OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1;                 end
            OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1;                 end
            OP_LOAD:   begin use_rs1 = 1'b1;                   wr_rd = 1'b1; end
            OP_OPIMM:  begin use_rs1 = 1'b1;                   wr_rd = 1'b1; end
            OP_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1;   wr_rd = 1'b1; end
            OP_JAL, OP_AUIPC, OP_LUI: wr_rd = 1'b1;
            default: ;
        endcase
    end

    // A used, non-x0 source matches a valid slot that writes that register.
    function automatic logic hit(slot_t s, logic [4:0] rs, logic used);
        return used && (rs != 5'd0) && s.valid && s.wr && (s.rd == rs);
    endfunction

    assign hit_ex_a  = hit(ex_slot,  bus.id_rs1, use_rs1);
    assign hit_ex_b  = hit(ex_slot,  bus.id_rs2, use_rs2);
    assign hit_mem_a = hit(mem_slot, bus.id_rs1, use_rs1);
    assign hit_mem_b = hit(mem_slot, bus.id_rs2, use_rs2);

`ifdef HAZARD_CTRL_FORWARD_EN
    // The load flag only matters while the producer sits in EX: one cycle
    // later its data is on the MEM/WB forward path.
    logic ex_load;
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;

    assign need_stall = bus.id_valid && ex_load && (hit_ex_a || hit_ex_b);
`else
    assign need_stall = bus.id_valid &&
                        (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
`endif

    // ------------------------------------------------------------------
    // Stall / flush outputs (redirect beats stall)
    // ------------------------------------------------------------------
    always_comb begin
        bus.stall_if = 1'b0;
        bus.stall_id = 1'b0;
        bus.flush_id = 1'b0;
        bus.flush_ex = 1'b0;
        // NOTE: reset is synchronous for state, but these combinational
        // controls are gated by rst_n so they stay low throughout reset.
        if (!rst_n) begin
            // all low
        end else if (bus.ex_redirect) begin
            bus.flush_id = 1'b1;
            bus.flush_ex = 1'b1;
        end else if (need_stall) begin
            bus.stall_if = 1'b1;
            bus.stall_id = 1'b1;
            bus.flush_ex = 1'b1;
        end
    end

    assign stall = bus.stall_id;
    assign issue = bus.id_valid && !stall && !bus.ex_redirect;

    // ------------------------------------------------------------------
    // Slot tracking: MEM <= EX, EX <= issued ID instruction or bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else begin
            mem_slot <= ex_slot;
            if (issue) begin
                ex_slot <= '{valid: 1'b1, rd: bus.id_rd, wr: wr_rd};
            end else begin
                ex_slot <= '0;
            end
        end
    end

`ifdef HAZARD_CTRL_FORWARD_EN
    // Forward selection is registered on issue so it is stable for the whole
    // EX cycle of the consumer; the ID-time EX slot becomes EX/MEM and the
    // ID-time MEM slot becomes MEM/WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_load <= 1'b0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            ex_load <= issue && (bus.id_opcode == OP_LOAD);
            if (issue) begin
                fwd_a_q <= hit_ex_a ? 2'b01 : (hit_mem_a ? 2'b10 : 2'b00);
                fwd_b_q <= hit_ex_b ? 2'b01 : (hit_mem_b ? 2'b10 : 2'b00);
            end else begin
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end
        end
    end

    assign bus.fwd_a = fwd_a_q;
    assign bus.fwd_b = fwd_b_q;
`else
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    // ------------------------------------------------------------------
    // RUN / STALL / FLUSH FSM; it drives only the stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
        end
    end

    always_comb begin
        state_next = RUN;
        if (bus.ex_redirect) begin
            state_next = FLUSH;
        end else begin
            case (state)
                RUN:     state_next = stall ? STALL : RUN;
                STALL:   state_next = stall ? STALL : RUN;
                FLUSH:   state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if ((state == STALL) && (cnt_q != 16'hFFFF)) begin
            cnt_next = cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl.  A reference model tracks the last two
// issued instructions by opcode and destination and derives the expected
// controls from the register-usage rules of the ISA.  Directed scenarios
// cover load-use, ALU chains, x0, stores, redirect-over-stall and mid-stall
// reset; a randomized phase follows.  Honours HAZARD_CTRL_FORWARD_EN.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam bit [6:0] OP_JALR   = 7'b1100111;
    localparam bit [6:0] OP_BRANCH = 7'b1100011;
    localparam bit [6:0] OP_STORE  = 7'b0100011;
    localparam bit [6:0] OP_LOAD   = 7'b0000011;
    localparam bit [6:0] OP_OPIMM  = 7'b0010011;
    localparam bit [6:0] OP_OP     = 7'b0110011;
    localparam bit [6:0] OP_JAL    = 7'b1101111;
    localparam bit [6:0] OP_AUIPC  = 7'b0010111;
    localparam bit [6:0] OP_LUI    = 7'b0110111;
    localparam bit [6:0] OP_SYSTEM = 7'b1110011;

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       valid;
        bit [6:0] op;
        bit [4:0] rd;
    } instr_t;

    typedef enum {P_RUN, P_STALL, P_FLUSH} phase_t;

    instr_t m_ex, m_mem;          // instructions currently in EX and MEM
    bit [1:0] m_fwd_a, m_fwd_b;
    int       m_cnt;
    phase_t   m_phase;
    bit       m_known = 1'b0;     // registered outputs defined after first reset

    function automatic bit reads_rs1(bit [6:0] op);
        return op inside {OP_JALR, OP_BRANCH, OP_STORE, OP_LOAD, OP_OPIMM, OP_OP};
    endfunction

    function automatic bit reads_rs2(bit [6:0] op);
        return op inside {OP_BRANCH, OP_STORE, OP_OP};
    endfunction

    function automatic bit writes_rd(bit [6:0] op);
        return op inside {OP_JALR, OP_JAL, OP_AUIPC, OP_LUI, OP_LOAD, OP_OPIMM, OP_OP};
    endfunction

    // Does reading register rs depend on the instruction in slot s?
    function automatic bit dep(instr_t s, bit [4:0] rs, bit used);
        return used && rs != 0 && s.valid && writes_rd(s.op) && s.rd == rs;
    endfunction

    // One clock cycle: apply inputs, compare at negedge, advance model at posedge.
    task automatic step(input bit v, input bit [6:0] op, input bit [4:0] r1,
                        input bit [4:0] r2, input bit [4:0] rd,
                        input bit redir, input bit rst,
                        output bit issued, output bit stalled);
        bit a_ex, b_ex, a_mem, b_mem, need, e_stall, e_flush;
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_rs1      = r1;
        bus.id_rs2      = r2;
        bus.id_rd       = rd;
        bus.ex_redirect = redir;
        rst_n           = !rst;

        a_ex  = dep(m_ex,  r1, reads_rs1(op));
        b_ex  = dep(m_ex,  r2, reads_rs2(op));
        a_mem = dep(m_mem, r1, reads_rs1(op));
        b_mem = dep(m_mem, r2, reads_rs2(op));
        if (FWD) need = v && m_ex.valid && m_ex.op == OP_LOAD && (a_ex || b_ex);
        else     need = v && (a_ex || b_ex || a_mem || b_mem);
        e_stall = !rst && !redir && need;
        e_flush = !rst && redir;

        @(negedge clk);
        check("stall_if", bus.stall_if, e_stall);
        check("stall_id", bus.stall_id, e_stall);
        check("flush_id", bus.flush_id, e_flush);
        check("flush_ex", bus.flush_ex, e_flush || e_stall);
        if (m_known) begin
            check("fwd_a",     bus.fwd_a,     m_fwd_a);
            check("fwd_b",     bus.fwd_b,     m_fwd_b);
            check("stall_cnt", bus.stall_cnt, m_cnt[15:0]);
        end

        issued  = !rst && v && !e_stall && !redir;
        stalled = e_stall;

        @(posedge clk);
        if (rst) begin
            m_ex     = '{0, 0, 0};
            m_mem    = '{0, 0, 0};
            m_fwd_a  = 0;
            m_fwd_b  = 0;
            m_cnt    = 0;
            m_phase  = P_RUN;
            m_known  = 1'b1;
        end else begin
            if (m_phase == P_STALL && m_cnt < 65535) m_cnt++;
            if (redir)                   m_phase = P_FLUSH;
            else if (m_phase == P_FLUSH) m_phase = P_RUN;
            else                         m_phase = e_stall ? P_STALL : P_RUN;
            if (FWD && issued) begin
                m_fwd_a = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
                m_fwd_b = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
            end else begin
                m_fwd_a = 2'b00;
                m_fwd_b = 2'b00;
            end
            m_mem = m_ex;
            m_ex  = issued ? '{1, op, rd} : '{0, 0, 0};
        end
        #1;
    endtask

    task automatic do_reset();
        bit iss, st;
        step(0, 0, 0, 0, 0, 0, 1, iss, st);
        step(0, 0, 0, 0, 0, 0, 1, iss, st);
    endtask

    // Present an instruction until it issues; returns stall cycles seen.
    task automatic run_instr(input bit [6:0] op, input bit [4:0] r1,
                             input bit [4:0] r2, input bit [4:0] rd,
                             output int stalls);
        bit iss, st;
        stalls = 0;
        iss = 0;
        for (int k = 0; k < 5 && !iss; k++) begin
            step(1, op, r1, r2, rd, 0, 0, iss, st);
            if (st) stalls++;
        end
        check("issue_within_budget", {15'd0, iss}, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        bit iss, st;
        bit [6:0] ops [10];
        bit       held;
        bit       cv, rd_redir, rd_rst;
        bit [6:0] cop;
        bit [4:0] c1, c2, cd;

        ops = '{OP_JALR, OP_BRANCH, OP_STORE, OP_LOAD, OP_OPIMM,
                OP_OP, OP_JAL, OP_AUIPC, OP_LUI, OP_SYSTEM};

        // Reset state
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, iss, st);
        check("reset_cnt", bus.stall_cnt, 16'd0);
        check("reset_fwd_a", bus.fwd_a, 2'b00);

        // lw x5,0(x1) ; add x6,x5,x7
        run_instr(OP_LOAD, 1, 0, 5, s);
        run_instr(OP_OP, 5, 7, 6, s);
        check("lu_stalls", s[15:0], FWD ? 16'd1 : 16'd2);
        check("lu_cnt", bus.stall_cnt, FWD ? 16'd1 : 16'd2);
        check("lu_fwd_a", bus.fwd_a, FWD ? 2'b10 : 2'b00);

        // addi x3,x0,1 ; sub x4,x3,x3
        do_reset();
        run_instr(OP_OPIMM, 0, 1, 3, s);
        run_instr(OP_OP, 3, 3, 4, s);
        check("alu_stalls", s[15:0], FWD ? 16'd0 : 16'd2);
        check("alu_fwd_a", bus.fwd_a, FWD ? 2'b01 : 2'b00);
        check("alu_fwd_b", bus.fwd_b, FWD ? 2'b01 : 2'b00);

        // addi x3,x0,1 ; add x4,x3,x0
        do_reset();
        run_instr(OP_OPIMM, 0, 1, 3, s);
        run_instr(OP_OP, 3, 0, 4, s);
        check("x0src_stalls", s[15:0], FWD ? 16'd0 : 16'd2);
        check("x0src_cnt", bus.stall_cnt, FWD ? 16'd0 : 16'd2);
        check("x0src_fwd_b", bus.fwd_b, 2'b00);

        // Load-use coinciding with redirect: redirect wins
        do_reset();
        run_instr(OP_LOAD, 1, 0, 5, s);
        step(1, OP_OP, 5, 7, 6, 1, 0, iss, st);
        check("redir_no_issue", {15'd0, iss}, 16'd0);
        step(0, 0, 0, 0, 0, 0, 0, iss, st);
        step(0, 0, 0, 0, 0, 0, 0, iss, st);
        check("redir_cnt", bus.stall_cnt, 16'd0);

        // add x0,x5,x5 ; add x6,x0,x0 ; sw x2,0(x1) ; add x7,x2,x2
        do_reset();
        run_instr(OP_OP, 5, 5, 0, s);
        run_instr(OP_OP, 0, 0, 6, s);
        check("x0dst_stalls", s[15:0], 16'd0);
        check("x0dst_fwd_a", bus.fwd_a, 2'b00);
        run_instr(OP_STORE, 1, 2, 2, s);
        run_instr(OP_OP, 2, 2, 7, s);
        check("store_stalls", s[15:0], 16'd0);

        // Reset for one cycle in the middle of a stall
        do_reset();
        run_instr(OP_LOAD, 1, 0, 5, s);
        step(1, OP_OP, 5, 7, 6, 0, 0, iss, st);
        check("pre_rst_stall", {15'd0, st}, 16'd1);
        step(1, OP_OP, 5, 7, 6, 0, 1, iss, st);
        step(1, OP_OP, 5, 7, 6, 0, 0, iss, st);
        check("post_rst_stall", {15'd0, st}, 16'd0);
        check("post_rst_cnt", bus.stall_cnt, 16'd0);

        // Randomized phase: stalled instructions stay in ID
        held = 0;
        cv = 0; cop = 0; c1 = 0; c2 = 0; cd = 0;
        for (int i = 0; i < 500; i++) begin
            if (!held) begin
                cv  = $urandom_range(0, 99) < 85;
                cop = ops[$urandom_range(0, 9)];
                c1  = 5'($urandom_range(0, 7));
                c2  = 5'($urandom_range(0, 7));
                cd  = 5'($urandom_range(0, 7));
            end
            rd_redir = $urandom_range(0, 99) < 10;
            rd_rst   = $urandom_range(0, 99) < 2;
            step(cv, cop, c1, c2, cd, rd_redir, rd_rst, iss, st);
            held = st;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
